// File: rtl/exec_writeback.sv
// rtl/exec_writeback.sv - execute-to-register-file writeback stage with 2-entry write FIFO and flag update
// Optional macro WB_BYPASS_EN enables the decode-stage forwarding lookup into pending writes.
module exec_writeback #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   in_op,
    input  logic [31:0]           in_data,
    input  logic [REG_ADDR_W-1:0] in_dst,
    input  logic                  in_wb,
    input  logic                  in_c,
    input  logic                  in_s,
    input  logic                  in_z,
    output logic                  rf_we,
    input  logic                  rf_ready,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  flag_c,
    output logic                  flag_s,
    output logic                  flag_z,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [31:0]           fwd_data
);

    // Opcode encodings shared with the ALU opcode definitions.
    localparam logic [ALU_OP_W-1:0] OP_CMP      = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_CGE      = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] OP_CGT      = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_THA_HALF = ALU_OP_W'(16);
    localparam logic [ALU_OP_W-1:0] OP_THB_HALF = ALU_OP_W'(17);
    localparam logic [ALU_OP_W-1:0] OP_THA_BYTE = ALU_OP_W'(18);
    localparam logic [ALU_OP_W-1:0] OP_THB_BYTE = ALU_OP_W'(19);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0]             data0_q, data0_d, data1_q, data1_d;
    logic                    fc_q, fc_d, fs_q, fs_d, fz_q, fz_d;

    logic                    accept;
    logic                    is_cmp;
    logic                    push;
    logic                    pop;
    logic [31:0]             wb_value;

    assign in_ready = (state_q != FULL);
    assign rf_we    = (state_q != EMPTY);
    assign rf_waddr = addr0_q;
    assign rf_wdata = data0_q;
    assign flag_c   = fc_q;
    assign flag_s   = fs_q;
    assign flag_z   = fz_q;

    assign accept = in_valid && in_ready;
    assign is_cmp = (in_op == OP_CMP) || (in_op == OP_CGE) || (in_op == OP_CGT);
    assign push   = accept && in_wb && (in_dst != '0) && !is_cmp;
    assign pop    = rf_we && rf_ready;

    always_comb begin
        wb_value = in_data;
        case (in_op)
            OP_THA_HALF, OP_THB_HALF: wb_value = {16'h0000, in_data[15:0]};
            OP_THA_BYTE, OP_THB_BYTE: wb_value = {24'h000000, in_data[7:0]};
            default:                  wb_value = in_data;
        endcase
    end

    // Entry 0 is always the head; entry 1 only holds data in FULL.
    always_comb begin
        state_d = state_q;
        addr0_d = addr0_q;
        data0_d = data0_q;
        addr1_d = addr1_q;
        data1_d = data1_q;
        fc_d    = fc_q;
        fs_d    = fs_q;
        fz_d    = fz_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    addr0_d = in_dst;
                    data0_d = wb_value;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        addr1_d = in_dst;
                        data1_d = wb_value;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: begin
                        addr0_d = in_dst;
                        data0_d = wb_value;
                    end
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (pop) begin
                    addr0_d = addr1_q;
                    data0_d = data1_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept && is_cmp) begin
            fc_d = in_c;
            fs_d = in_s;
            fz_d = in_z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            addr0_q <= '0;
            data0_q <= '0;
            addr1_q <= '0;
            data1_q <= '0;
            fc_q    <= 1'b0;
            fs_q    <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr0_q <= addr0_d;
            data0_q <= data0_d;
            addr1_q <= addr1_d;
            data1_q <= data1_d;
            fc_q    <= fc_d;
            fs_q    <= fs_d;
            fz_q    <= fz_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Newest pending write wins: entry 1 is younger than entry 0 when FULL.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (state_q == FULL && addr1_q == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data1_q;
            end else if (state_q != EMPTY && addr0_q == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data0_q;
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_exec_writeback.sv
// tb/tb_exec_writeback.sv - self-checking bench for exec_writeback against a queue-based model
module tb_exec_writeback;

    localparam int AW = 5;
    localparam int OW = 5;

    localparam logic [4:0] ADD      = 5'd0;
    localparam logic [4:0] CMP      = 5'd8;
    localparam logic [4:0] CGE      = 5'd9;
    localparam logic [4:0] CGT      = 5'd10;
    localparam logic [4:0] THA_HALF = 5'd16;
    localparam logic [4:0] THB_HALF = 5'd17;
    localparam logic [4:0] THA_BYTE = 5'd18;
    localparam logic [4:0] THB_BYTE = 5'd19;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_wb, in_c, in_s, in_z;
    logic [OW-1:0] in_op;
    logic [31:0]   in_data;
    logic [AW-1:0] in_dst;
    logic          rf_we, rf_ready;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          flag_c, flag_s, flag_z;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    always #5 clk = ~clk;

    exec_writeback #(.REG_ADDR_W(AW), .ALU_OP_W(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .in_dst(in_dst), .in_wb(in_wb), .in_c(in_c), .in_s(in_s), .in_z(in_z),
        .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    logic mc, ms, mz;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_flag_op(input logic [4:0] op);
        return (op == CMP) || (op == CGE) || (op == CGT);
    endfunction

    function automatic logic [31:0] stored_value(input logic [4:0] op, input logic [31:0] d);
        if (op == THA_HALF || op == THB_HALF) return d & 32'h0000FFFF;
        if (op == THA_BYTE || op == THB_BYTE) return d & 32'h000000FF;
        return d;
    endfunction

    task automatic check_outputs();
        logic        exp_hit;
        logic [31:0] exp_fd;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("rf_we", 32'(rf_we), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(mq[0].a));
            chk("rf_wdata", rf_wdata, mq[0].d);
        end
        chk("flags", {29'd0, flag_c, flag_s, flag_z}, {29'd0, mc, ms, mz});
        exp_hit = 1'b0;
        exp_fd  = 32'd0;
`ifdef WB_BYPASS_EN
        if (fwd_addr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!exp_hit && mq[i].a == fwd_addr) begin
                    exp_hit = 1'b1;
                    exp_fd  = mq[i].d;
                end
            end
        end
`endif
        chk("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
        chk("fwd_data", fwd_data, exp_fd);
    endtask

    // Drive one cycle from a negedge, check before the rising edge, advance the model.
    task automatic cycle(input logic v, input logic [4:0] op, input logic [31:0] d,
                         input logic [4:0] dst, input logic wb, input logic c, input logic s,
                         input logic z, input logic rdy, input logic [4:0] fa);
        logic acc, popd;
        ent_t e;
        in_valid = v; in_op = op; in_data = d; in_dst = dst; in_wb = wb;
        in_c = c; in_s = s; in_z = z; rf_ready = rdy; fwd_addr = fa;
        #1;
        check_outputs();
        acc  = v && (mq.size() < 2);
        popd = (mq.size() > 0) && rdy;
        @(posedge clk);
        if (popd) void'(mq.pop_front());
        if (acc) begin
            if (is_flag_op(op)) begin
                mc = c; ms = s; mz = z;
            end else if (wb && dst != 5'd0) begin
                e.a = dst;
                e.d = stored_value(op, d);
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, ADD, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_flags", {29'd0, flag_c, flag_s, flag_z}, 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        mq.delete();
        mc = 1'b0; ms = 1'b0; mz = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_op = ADD; in_data = 32'd0; in_dst = 5'd0; in_wb = 1'b0;
        in_c = 1'b0; in_s = 1'b0; in_z = 1'b0; rf_ready = 1'b0; fwd_addr = 5'd0;
        mc = 1'b0; ms = 1'b0; mz = 1'b0;
        @(negedge clk);
        do_reset();

        // Single ADD writes r3 one cycle after acceptance, then the FIFO drains.
        cycle(1'b1, ADD, 32'h7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("add_rf_we", 32'(rf_we), 32'd1);
        chk("add_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("add_rf_wdata", rf_wdata, 32'h7);
        idle(1'b1);
        #1;
        chk("add_drained", 32'(rf_we), 32'd0);

        // Byte / half zero-extension; the half push coincides with the byte pop.
        cycle(1'b1, THA_BYTE, 32'hDEADBEEF, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("byte_wdata", rf_wdata, 32'h000000EF);
        cycle(1'b1, THA_HALF, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("half_wdata", rf_wdata, 32'h0000BEEF);
        chk("half_waddr", 32'(rf_waddr), 32'd6);
        idle(1'b1);

        // r0 destination is consumed without a write.
        cycle(1'b1, ADD, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("r0_no_write", 32'(rf_we), 32'd0);

        // Stalled register file: two entries fill the FIFO, third waits, drain in order.
        cycle(1'b1, ADD, 32'h101, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, ADD, 32'h102, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("drain_first", 32'(rf_waddr), 32'd1);
        cycle(1'b1, ADD, 32'h103, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, ADD, 32'h103, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("drain_second", 32'(rf_waddr), 32'd2);
        cycle(1'b1, ADD, 32'h103, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        chk("third_accepted", 32'(rf_waddr), 32'd3);
        chk("third_data", rf_wdata, 32'h103);
        idle(1'b1);
        idle(1'b1);

        // Compare updates flags only.
        cycle(1'b1, CGE, 32'h1234, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        #1;
        chk("cge_flags", {29'd0, flag_c, flag_s, flag_z}, 32'b101);
        chk("cge_no_write", 32'(rf_we), 32'd0);

        // Two pending writes to r5, forwarding lookup, then reset while FULL and stalled.
        cycle(1'b1, ADD, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, ADD, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        in_valid = 1'b0;
        fwd_addr = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        chk("fwd_r5_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_r5_data", fwd_data, 32'h22);
`else
        chk("fwd_off_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_off_data", fwd_data, 32'd0);
`endif
        fwd_addr = 5'd0;
        #1;
        chk("fwd_r0_hit", 32'(fwd_hit), 32'd0);
        chk("stalled_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            #1;
            chk("no_write_after_rst", 32'(rf_we), 32'd0);
        end

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ops[11];
            logic [4:0] op;
            ops = '{ADD, 5'd1, 5'd3, CMP, CGE, CGT, THA_HALF, THB_HALF, THA_BYTE, THB_BYTE, 5'd31};
            op  = ops[$urandom_range(0, 10)];
            cycle(1'($urandom_range(0, 3) != 0), op, $urandom(), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_writeback.md
EXEC_WRITEBACK -- requirements
Module: exec_writeback

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, giving the register address width.
REQ-002 SHALL have parameter ALU_OP_W, default 5, matching the `ALU_OPCODE` width in op_def.v.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  execute result present.
REQ-006 SHALL have port in_ready  output  1  block accepts a result this cycle.
REQ-007 SHALL have port in_op  input  ALU_OP_W  ALU opcode of the result.
REQ-008 SHALL have port in_data  input  32  ALU out.
REQ-009 SHALL have port in_dst  input  REG_ADDR_W  destination register.
REQ-010 SHALL have port in_wb  input  1  instruction writes a register.
REQ-011 SHALL have ports in_c, in_s, in_z  input  1 each  ALU carry/sign/zero.
REQ-012 SHALL have port rf_we  output  1  register-file write request.
REQ-013 SHALL have port rf_ready  input  1  register file accepts the write this cycle.
REQ-014 SHALL have port rf_waddr  output  REG_ADDR_W  write address.
REQ-015 SHALL have port rf_wdata  output  32  write data.
REQ-016 SHALL have ports flag_c, flag_s, flag_z  output  1 each  architectural flags.
REQ-017 SHALL have port fwd_addr  input  REG_ADDR_W  decode-stage lookup address.
REQ-018 SHALL have ports fwd_hit  output  1 and fwd_data  output  32  forwarding result.

Function
REQ-019 SHALL accept a result on a rising edge where in_valid and in_ready are both 1.
REQ-020 SHALL hold a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-021 SHALL drive in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL; in_ready SHALL depend only on registered state.
REQ-022 SHALL push an accepted result only when in_wb=1, in_dst!=0 and in_op is not CMP/CGE/CGT.
REQ-023 SHALL accept other results without pushing them, so that they are consumed.
REQ-024 SHALL store write data per opcode: THA_HALF/THB_HALF = zero-extended in_data[15:0], THA_BYTE/THB_BYTE = zero-extended in_data[7:0], all other opcodes = in_data.
REQ-025 SHALL drive rf_we=1 whenever the FIFO is non-empty, with rf_waddr/rf_wdata taken from the head entry.
REQ-026 SHALL pop the head on an edge where rf_we and rf_ready are both 1.
REQ-027 SHALL, on a simultaneous push and pop in ONE, remain in ONE with the new entry at the head.
REQ-028 SHALL hold the head stable while rf_ready=0; there is no timeout.
REQ-029 SHALL, on an accepted CMP/CGE/CGT, load in_c/in_s/in_z into flag_c/flag_s/flag_z at that edge; other opcodes SHALL leave the flags unchanged.
REQ-030 SHALL add zero cycles of latency between acceptance and rf_we, which SHALL assert in the cycle after the accepting edge.

Reset
REQ-031 SHALL, while rst=1, force the FIFO to EMPTY, rf_we=0, rf_waddr=0, rf_wdata=0, flags=0, fwd_hit=0 and fwd_data=0.
REQ-032 SHALL discard pending entries when rst is asserted mid-operation, with no register-file write issued for them.
REQ-033 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-034 SHALL, with WB_BYPASS_EN defined, compare fwd_addr combinationally against valid entries, newest first, and drive fwd_hit=1 with that entry's stored data on a match.
REQ-035 SHALL return fwd_hit=0 for fwd_addr=0.
REQ-036 SHALL, without WB_BYPASS_EN, tie fwd_hit=0 and fwd_data=0 and include no comparator logic.

Verification
REQ-037 SHALL test: reset, then ADD in_data=0x00000007, in_dst=3, in_wb=1, with rf_ready=1 -> rf_we=1, rf_waddr=3, rf_wdata=0x7 one cycle later, then the FIFO is empty.
REQ-038 SHALL test: THA_BYTE in_data=0xDEADBEEF -> rf_wdata=0x000000EF; THA_HALF -> 0x0000BEEF.
REQ-039 SHALL test: rf_ready=0 with three back-to-back pushes -> in_ready=0 after two; raising rf_ready drains dst order 1, 2, then the third is accepted.
REQ-040 SHALL test: CGE with in_c=1, in_s=0, in_z=1 and in_wb=1 -> flags become 1/0/1, with no rf_we.
REQ-041 SHALL test: WB_BYPASS_EN defined, two pending writes to r5 (0x11, then 0x22), fwd_addr=5 -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0.
REQ-042 SHALL test: rst pulsed while FULL and stalled -> rf_we=0 immediately, with no write issued after release.
